axi_lite_rd_issuer: RTL and testbench
=====================================

Name: axi_lite_rd_issuer

Overview:
- Downstream consumer of the 8-deep, 32-bit, non-fall-through transaction FIFO.
- Pops one read address at a time from the FIFO and issues it as an AXI4-Lite read (AR channel).
- Captures the R beat and presents data plus error flag on a valid/ready result port.
- One outstanding transaction; strictly in order.

Parameters:
- ADDR_WIDTH, 32, address width; matches the FIFO entry width.
- DATA_WIDTH, 32, R data and result data width.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- TIMEOUT_CYCLES, 256, cycles waited in RESP before a forced error; used only with the optional feature; must be at least 2.

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active low.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  ADDR_WIDTH  FIFO head entry; valid when fifo_empty_i=0.
- fifo_pop_o  out  1  pop FIFO head this cycle.
- ar_addr_o  out  ADDR_WIDTH  AXI AR address.
- ar_prot_o  out  3  AXI AR prot; constant 3'b000.
- ar_valid_o  out  1  AXI AR valid.
- ar_ready_i  in  1  AXI AR ready.
- r_data_i  in  DATA_WIDTH  AXI R data.
- r_resp_i  in  2  AXI R resp.
- r_valid_i  in  1  AXI R valid.
- r_ready_o  out  1  AXI R ready.
- rsp_data_o  out  DATA_WIDTH  result data.
- rsp_err_o  out  1  result error: SLVERR, DECERR or timeout.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result ready.
- busy_o  out  1  state is not IDLE.
- err_cnt_o  out  ERR_CNT_WIDTH  saturating count of errored results.

Behaviour:
- Reset: state=IDLE. All outputs 0: addr, data, err, valids, readies, pop, err_cnt, busy.
- FSM states: IDLE, ADDR, RESP, DELIVER.
- IDLE: fifo_pop_o = (state==IDLE) & ~fifo_empty_i, combinational.
  - When popping, register addr = fifo_data_i with bits [1:0] forced to 0 (word aligned), then go to ADDR.
- ADDR: ar_valid_o=1; ar_addr_o holds stable until handshake.
  - On ar_valid_o & ar_ready_i, go to RESP.
  - ar_valid_o never drops before the handshake (AXI rule).
- RESP: r_ready_o=1.
  - On r_valid_i, register data = r_data_i and err = r_resp_i[1], then go to DELIVER.
- DELIVER: rsp_valid_o=1; data and err are held until rsp_ready_i.
  - On handshake, go to IDLE.
  - If err=1, err_cnt increments on the handshake cycle, saturating at all-ones.
- r_ready_o=0 outside RESP; R beats arriving then are not accepted.
- Throughput: 4 cycles per transaction minimum with all readies high.
  - FIFO non-empty at cycle 0: pop at 0, ar_valid at 1, R accepted at 2, rsp_valid at 3, next pop at 4.
- No new pop until the DELIVER handshake completes, so FIFO backpressure is natural.
- Asynchronous reset mid-transaction: abort to IDLE, all outputs 0. The AXI slave is reset on the same rst_ni.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES) bits clears on entering RESP and counts while r_valid_i=0.
  - When it reaches TIMEOUT_CYCLES-1, go to DELIVER with data=0 and err=1.
  - A sticky orphan bit is then set. While orphan=1, r_ready_o=1 in every state and no pop/AR is issued from IDLE.
  - The next r_valid_i clears orphan and its beat is discarded.
  - An R beat arriving in the same cycle as the timeout wins: normal capture, no orphan.
- Undefined: no counter, no orphan bit; RESP waits forever.

Decomposition:
- Package axi_rd_pkg holds:
  - state enum rd_state_e {IDLE, ADDR, RESP, DELIVER};
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - addr_t/data_t typedefs of 32 bits.
- No sub-module; the saturating counter stays inline.

Test Plan:
- Push 0x1000, 0x1004, 0x1008 into the FIFO, all readies high, slave returns addr^0xFFFF_FFFF with OKAY -> three results in order (0xFFFF_EFFF, 0xFFFF_EFFB, 0xFFFF_EFF7), err=0, first rsp_valid 3 cycles after the first pop, 4-cycle spacing.
- Push 0x2003 -> ar_addr_o=0x2000.
- Hold ar_ready_i=0 for 5 cycles -> ar_valid_o stays 1 with addr constant, no further pop.
- Slave returns SLVERR, then DECERR, then OKAY -> rsp_err_o=1,1,0 and err_cnt_o=2.
- 300 SLVERR transactions -> err_cnt_o saturates at 255.
- rsp_ready_i low 10 cycles in DELIVER -> rsp_data_o stable, FIFO not popped, r_ready_o=0.
- With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave withholds R for 16 cycles -> rsp_err_o=1, rsp_data_o=0.
  - Then the late R beat is absorbed, and the next AR is issued only after it.

Source files
------------

// File: rtl/axi_lite_rd_issuer_pkg.sv
// Shared types and constants for the AXI4-Lite read issuer.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    RESP    = 2'd2,
    DELIVER = 2'd3
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  // SLVERR and DECERR are the only erroring responses (resp[1] set).
  function automatic logic is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_rd_issuer_if.sv
// FIFO, AXI4-Lite AR/R and result-port signals of the read issuer.
// master: the issuer itself; slave: FIFO, AXI slave and result consumer side.
interface axi_lite_rd_issuer_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
);
  logic                     fifo_empty_i;
  logic [ADDR_WIDTH-1:0]    fifo_data_i;
  logic                     fifo_pop_o;
  logic [ADDR_WIDTH-1:0]    ar_addr_o;
  logic [2:0]               ar_prot_o;
  logic                     ar_valid_o;
  logic                     ar_ready_i;
  logic [DATA_WIDTH-1:0]    r_data_i;
  logic [1:0]               r_resp_i;
  logic                     r_valid_i;
  logic                     r_ready_o;
  logic [DATA_WIDTH-1:0]    rsp_data_o;
  logic                     rsp_err_o;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic                     busy_o;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, ar_ready_i, r_data_i, r_resp_i, r_valid_i, rsp_ready_i,
    output fifo_pop_o, ar_addr_o, ar_prot_o, ar_valid_o, r_ready_o, rsp_data_o, rsp_err_o,
           rsp_valid_o, busy_o, err_cnt_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ar_ready_i, r_data_i, r_resp_i, r_valid_i, rsp_ready_i,
    input  fifo_pop_o, ar_addr_o, ar_prot_o, ar_valid_o, r_ready_o, rsp_data_o, rsp_err_o,
           rsp_valid_o, busy_o, err_cnt_o
  );

endinterface

// File: rtl/axi_lite_rd_issuer.sv
// Pops read addresses from the transaction FIFO, issues them one at a time as
// AXI4-Lite reads and presents each R beat on a valid/ready result port.
// Optional macro AXI_RD_TIMEOUT_EN: bounded wait in RESP with orphan-beat absorption.
module axi_lite_rd_issuer
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ERR_CNT_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  axi_lite_rd_issuer_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  rd_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     pop;
  logic                     blocked;

`ifdef AXI_RD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            orphan_q, orphan_d;

  // A timed-out read may still return a beat; hold off new reads until it drains.
  assign blocked = orphan_q;
`else
  assign blocked = 1'b0;
`endif

  // Next-state logic for the transaction FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    pop       = 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
    tmo_d    = tmo_q;
    orphan_d = orphan_q;
    if (orphan_q && bus.r_valid_i) begin
      orphan_d = 1'b0;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_empty_i && !blocked) begin
          pop     = 1'b1;
          addr_d  = {bus.fifo_data_i[ADDR_WIDTH-1:2], 2'b00};
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus.ar_ready_i) begin
          state_d = RESP;
`ifdef AXI_RD_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end
      RESP: begin
        if (bus.r_valid_i) begin
          data_d  = bus.r_data_i;
          err_d   = is_err(bus.r_resp_i);
          state_d = DELIVER;
`ifdef AXI_RD_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          data_d   = '0;
          err_d    = 1'b1;
          orphan_d = 1'b1;
          state_d  = DELIVER;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      DELIVER: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
          if (err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  // Timeout counter and orphan flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      orphan_q <= orphan_d;
    end
  end
`endif

  assign bus.fifo_pop_o  = pop;
  assign bus.ar_addr_o   = addr_q;
  assign bus.ar_prot_o   = 3'b000;
  assign bus.ar_valid_o  = (state_q == ADDR);
  assign bus.r_ready_o   = (state_q == RESP) || blocked;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.rsp_valid_o = (state_q == DELIVER);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_rd_issuer.sv
// Self-checking bench for axi_lite_rd_issuer: FIFO and AXI slave models,
// scoreboard of expected results checked by an independent monitor.
module tb_axi_lite_rd_issuer;
  import axi_rd_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Bench models and scoreboard.
  logic [31:0] fifo_q[$];
  logic [31:0] exp_ar_q[$];
  logic [1:0]  resp_q[$];
  exp_t        exp_q[$];
  int          pop_cyc[$];
  int          ar_cyc[$];
  int          r_cyc[$];
  int          rsp_cyc[$];

  // Slave state and knobs set by the main sequence.
  logic        pend_valid = 1'b0;
  logic [31:0] pend_addr  = '0;
  logic [1:0]  pend_resp  = RESP_OKAY;
  logic        ar_ready_en  = 1'b1;
  logic        r_valid_en   = 1'b1;
  logic        rsp_ready_en = 1'b1;

  axi_lite_rd_issuer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) bus ();

  axi_lite_rd_issuer #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .ERR_CNT_WIDTH (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic push_txn(input logic [31:0] addr, input logic [31:0] ar, input logic [1:0] resp,
                          input logic [31:0] data, input logic err);
    fifo_q.push_back(addr);
    exp_ar_q.push_back(ar);
    resp_q.push_back(resp);
    exp_q.push_back('{data: data, err: err});
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.busy_o) && n < bound) begin
      step();
      n++;
    end
    check({name, " drain timeout"}, 64'(n >= bound), 64'(0));
  endtask

  // Drives FIFO/AXI/result inputs at negedge, then records the handshakes
  // that the coming rising edge will complete.
  initial begin
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i  = '0;
    bus.ar_ready_i   = 1'b0;
    bus.r_data_i     = '0;
    bus.r_resp_i     = RESP_OKAY;
    bus.r_valid_i    = 1'b0;
    bus.rsp_ready_i  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) continue;
      bus.fifo_empty_i = (fifo_q.size() == 0);
      bus.fifo_data_i  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
      bus.ar_ready_i   = ar_ready_en;
      bus.r_valid_i    = pend_valid && r_valid_en;
      bus.r_data_i     = pend_addr ^ 32'hFFFF_FFFF;
      bus.r_resp_i     = pend_resp;
      bus.rsp_ready_i  = rsp_ready_en;
      #1;
      if (bus.fifo_pop_o) begin
        pop_cyc.push_back(cyc);
        void'(fifo_q.pop_front());
      end
      if (bus.r_valid_i && bus.r_ready_o) begin
        r_cyc.push_back(cyc);
        pend_valid = 1'b0;
      end
      if (bus.ar_valid_o && bus.ar_ready_i) begin
        ar_cyc.push_back(cyc);
        if (exp_ar_q.size() == 0) begin
          check("unexpected ar", 64'(bus.ar_addr_o), 64'hDEAD);
        end else begin
          check("ar_addr", 64'(bus.ar_addr_o), 64'(exp_ar_q.pop_front()));
        end
        pend_valid = 1'b1;
        pend_addr  = bus.ar_addr_o;
        pend_resp  = (resp_q.size() == 0) ? RESP_OKAY : resp_q.pop_front();
      end
    end
  end

  // Result monitor: compares each delivered result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected rsp", 64'(bus.rsp_data_o), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(bus.rsp_data_o), 64'(e.data));
          check("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset ctrl", 64'({bus.fifo_pop_o, bus.ar_valid_o, bus.r_ready_o, bus.rsp_valid_o,
                             bus.busy_o, bus.rsp_err_o, bus.ar_prot_o}), 64'(0));
    check("reset ar_addr", 64'(bus.ar_addr_o), 64'(0));
    check("reset rsp_data", 64'(bus.rsp_data_o), 64'(0));
    check("reset err_cnt", 64'(bus.err_cnt_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back OKAY reads with all readies high.
    push_txn(32'h1000, 32'h1000, RESP_OKAY, 32'hFFFF_EFFF, 1'b0);
    push_txn(32'h1004, 32'h1004, RESP_OKAY, 32'hFFFF_EFFB, 1'b0);
    push_txn(32'h1008, 32'h1008, RESP_OKAY, 32'hFFFF_EFF7, 1'b0);
    drain("stream", 200);
    check("pop count", 64'(pop_cyc.size()), 64'(3));
    check("rsp count", 64'(rsp_cyc.size()), 64'(3));
    if (pop_cyc.size() >= 2 && ar_cyc.size() >= 1 && r_cyc.size() >= 1 && rsp_cyc.size() >= 3)
    begin
      check("ar latency", 64'(ar_cyc[0] - pop_cyc[0]), 64'(1));
      check("r latency", 64'(r_cyc[0] - pop_cyc[0]), 64'(2));
      check("rsp latency", 64'(rsp_cyc[0] - pop_cyc[0]), 64'(3));
      check("pop spacing", 64'(pop_cyc[1] - pop_cyc[0]), 64'(4));
      check("rsp spacing 1", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'(4));
      check("rsp spacing 2", 64'(rsp_cyc[2] - rsp_cyc[1]), 64'(4));
    end

    // Unaligned address is word aligned on AR.
    push_txn(32'h2003, 32'h2000, RESP_OKAY, 32'hFFFF_DFFF, 1'b0);
    drain("align", 100);

    // AR backpressure: address held, no further pop.
    ar_ready_en = 1'b0;
    push_txn(32'h3000, 32'h3000, RESP_OKAY, 32'hFFFF_CFFF, 1'b0);
    push_txn(32'h3004, 32'h3004, RESP_OKAY, 32'hFFFF_CFFB, 1'b0);
    n = 0;
    while (!bus.ar_valid_o && n < 20) begin step(); n++; end
    check("ar_valid wait", 64'(n >= 20), 64'(0));
    for (int i = 0; i < 5; i++) begin
      check("ar stall valid", 64'(bus.ar_valid_o), 64'(1));
      check("ar stall addr", 64'(bus.ar_addr_o), 64'h3000);
      check("ar stall pop", 64'(bus.fifo_pop_o), 64'(0));
      step();
    end
    ar_ready_en = 1'b1;
    drain("ar stall", 100);

    // Error responses and counter.
    push_txn(32'h4000, 32'h4000, RESP_SLVERR, 32'hFFFF_BFFF, 1'b1);
    push_txn(32'h4004, 32'h4004, RESP_DECERR, 32'hFFFF_BFFB, 1'b1);
    push_txn(32'h4008, 32'h4008, RESP_OKAY,   32'hFFFF_BFF7, 1'b0);
    drain("errors", 100);
    check("err_cnt two", 64'(bus.err_cnt_o), 64'(2));

    // Result backpressure: data held, no pop, R not accepted.
    rsp_ready_en = 1'b0;
    push_txn(32'h5000, 32'h5000, RESP_OKAY, 32'hFFFF_AFFF, 1'b0);
    push_txn(32'h5004, 32'h5004, RESP_OKAY, 32'hFFFF_AFFB, 1'b0);
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin step(); n++; end
    check("rsp_valid wait", 64'(n >= 20), 64'(0));
    for (int i = 0; i < 10; i++) begin
      check("rsp stall valid", 64'(bus.rsp_valid_o), 64'(1));
      check("rsp stall data", 64'(bus.rsp_data_o), 64'hFFFF_AFFF);
      check("rsp stall pop", 64'(bus.fifo_pop_o), 64'(0));
      check("rsp stall r_ready", 64'(bus.r_ready_o), 64'(0));
      step();
    end
    rsp_ready_en = 1'b1;
    drain("rsp stall", 100);

    // Saturation: 300 SLVERR reads through an 8-deep FIFO.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'h0001_0000 + 32'(i * 4);
      while (fifo_q.size() >= 8) step();
      push_txn(a, a, RESP_SLVERR, a ^ 32'hFFFF_FFFF, 1'b1);
    end
    drain("saturate", 5000);
    check("err_cnt saturated", 64'(bus.err_cnt_o), 64'(255));

`ifdef AXI_RD_TIMEOUT_EN
    // Slave withholds R: forced error, late beat absorbed, then next AR.
    r_valid_en = 1'b0;
    push_txn(32'h6000, 32'h6000, RESP_OKAY, 32'h0000_0000, 1'b1);
    push_txn(32'h6004, 32'h6004, RESP_OKAY, 32'hFFFF_9FFB, 1'b0);
    n = 0;
    while (exp_q.size() > 1 && n < 100) begin step(); n++; end
    check("timeout wait", 64'(n >= 100), 64'(0));
    if (rsp_cyc.size() != 0 && ar_cyc.size() != 0) begin
      check("timeout latency", 64'(rsp_cyc[$] - ar_cyc[$]), 64'(17));
    end
    step();
    for (int i = 0; i < 5; i++) begin
      check("orphan pop", 64'(bus.fifo_pop_o), 64'(0));
      check("orphan ar_valid", 64'(bus.ar_valid_o), 64'(0));
      check("orphan r_ready", 64'(bus.r_ready_o), 64'(1));
      step();
    end
    r_valid_en = 1'b1;
    drain("orphan", 100);
    check("err_cnt after timeout", 64'(bus.err_cnt_o), 64'(255));
`endif

    check("scoreboard empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
